// File: rtl/nibble_mem_bridge.sv
// nibble_mem_bridge
//   Bridges a byte-wide CPU output bus to a word-wide memory and IO space.
//   Each bus_out byte is decoded every cycle:
//     1 s a[5:0]      address phase (s=1 load, s=0 shift in 6 bits)
//     0 1 1 d[4:0]    select IO device d, pulse io_re
//     0 1 0 x         leave IO mode
//     0 0 w l n[3:0]  data phase: w=1 assemble nibble (l=1 commits),
//                     w=0,l=1 advance read pointer, w=0,l=0 no-op
//   Write words are assembled most significant nibble first. Read data is
//   returned one nibble at a time on bus_in.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   bus_out  [7:0]     CPU command/data byte
//   bus_in   [3:0]     nibble returned to the CPU (combinational)
//   mem_addr/mem_wdata registered memory address / write word
//   mem_we             one-cycle memory write strobe
//   mem_rdata          memory read word (combinational from mem_addr)
//   io_active, io_sel  IO mode flag and selected device
//   io_re, io_we       one-cycle IO read / write strobes
//   io_rdata           IO read word
//
// Configuration
//   NMB_AUTOINC_EN  when defined, mem_addr increments after each memory
//                   write strobe and on read-pointer wrap in memory mode.
module nibble_mem_bridge #(
  parameter int WORD_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            bus_out,
  output logic [3:0]            bus_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic                  io_active,
  output logic [4:0]            io_sel,
  output logic                  io_re,
  output logic                  io_we,
  input  logic [WORD_WIDTH-1:0] io_rdata
);

  localparam int NIBBLES = WORD_WIDTH / 4;
  localparam int PTR_W   = $clog2(NIBBLES);

  logic [WORD_WIDTH-1:0] assembly;
  logic [WORD_WIDTH-1:0] assembly_next;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_wrap;
  logic [ADDR_WIDTH-1:0] addr_load;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [WORD_WIDTH-1:0] rd_word;

  logic is_addr, is_io_sel, is_io_clr, is_data;
  logic dat_w, dat_l;

  assign is_addr   = bus_out[7];
  assign is_io_sel = (bus_out[7:5] == 3'b011);
  assign is_io_clr = (bus_out[7:5] == 3'b010);
  assign is_data   = (bus_out[7:6] == 2'b00);
  assign dat_w     = bus_out[5];
  assign dat_l     = bus_out[4];

  // Oldest nibble falls off the top once a full word has been shifted in.
  assign assembly_next = {assembly[WORD_WIDTH-5:0], bus_out[3:0]};
  assign rd_wrap       = (rd_ptr == PTR_W'(NIBBLES - 1));
  assign addr_load     = ADDR_WIDTH'(bus_out[5:0]);

  generate
    if (ADDR_WIDTH > 6) begin : g_shift
      assign addr_shift = {mem_addr[ADDR_WIDTH-7:0], bus_out[5:0]};
    end else begin : g_noshift
      assign addr_shift = bus_out[5:0];
    end
  endgenerate

  assign rd_word = io_active ? io_rdata : mem_rdata;

  // Pointer 0 selects the most significant nibble.
  always_comb begin
    bus_in = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (rd_ptr == PTR_W'(i)) bus_in = rd_word[(NIBBLES-1-i)*4 +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      assembly  <= '0;
      rd_ptr    <= '0;
      io_sel    <= '0;
      io_active <= 1'b0;
      mem_we    <= 1'b0;
      io_we     <= 1'b0;
      io_re     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      io_we  <= 1'b0;
      io_re  <= 1'b0;
`ifdef NMB_AUTOINC_EN
      // Post-write increment; an address phase below overrides it.
      if (mem_we) mem_addr <= mem_addr + ADDR_WIDTH'(1);
`endif
      if (is_addr) begin
        mem_addr  <= bus_out[6] ? addr_load : addr_shift;
        io_active <= 1'b0;
        rd_ptr    <= '0;
      end else if (is_io_sel) begin
        io_active <= 1'b1;
        io_sel    <= bus_out[4:0];
        rd_ptr    <= '0;
        io_re     <= 1'b1;
      end else if (is_io_clr) begin
        io_active <= 1'b0;
      end else if (is_data) begin
        if (dat_w) begin
          if (dat_l) begin
            mem_wdata <= assembly_next;
            assembly  <= '0;
            if (io_active) io_we  <= 1'b1;
            else           mem_we <= 1'b1;
          end else begin
            assembly <= assembly_next;
          end
        end else if (dat_l) begin
          rd_ptr <= rd_wrap ? '0 : rd_ptr + PTR_W'(1);
`ifdef NMB_AUTOINC_EN
          if (rd_wrap && !io_active) mem_addr <= mem_addr + ADDR_WIDTH'(1);
`endif
        end
      end
    end
  end

endmodule

// File: doc/nibble_mem_bridge.md
NIBBLE_MEM_BRIDGE -- requirements
Module: nibble_mem_bridge

Interface
REQ-001 Parameter WORD_WIDTH, 12, data word width in bits; SHALL be a multiple of 4, range 8..32; NIBBLES = WORD_WIDTH/4.
REQ-002 Parameter ADDR_WIDTH, 12, memory address width in bits; range 6..24.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 bus_out  in  8  CPU output byte, decoded every cycle.
REQ-006 bus_in  out  4  nibble returned to CPU.
REQ-007 mem_addr  out  ADDR_WIDTH  registered memory address.
REQ-008 mem_wdata  out  WORD_WIDTH  registered write word.
REQ-009 mem_we  out  1  memory write strobe, one cycle.
REQ-010 mem_rdata  in  WORD_WIDTH  memory read word, combinational from mem_addr.
REQ-011 io_active  out  1  IO mode flag.
REQ-012 io_sel  out  5  selected IO device.
REQ-013 io_re  out  1  IO read strobe, one cycle.
REQ-014 io_we  out  1  IO write strobe, one cycle.
REQ-015 io_rdata  in  WORD_WIDTH  IO read word.

Function
REQ-016 bus_out = 1,s,a[5:0] (address phase) SHALL: s=1 load mem_addr <= a zero-extended; s=0 shift mem_addr <= {mem_addr[ADDR_WIDTH-7:0], a}; clear io_active; clear read pointer.
REQ-017 bus_out = 0,1,1,d[4:0] SHALL set io_active, io_sel <= d, clear read pointer, pulse io_re next cycle.
REQ-018 bus_out = 0,1,0,x SHALL clear io_active; other state unchanged.
REQ-019 bus_out = 0,0,w,l,n[3:0] (data phase), w=1: assembly <= {assembly, n} (MS nibble first, oldest nibble dropped beyond NIBBLES).
REQ-020 Data phase with w=1,l=1 SHALL commit: mem_wdata <= assembled word (missing upper nibbles zero), assembly cleared, and in the following cycle exactly one of mem_we (io_active=0) or io_we (io_active=1) high for one cycle.
REQ-021 mem_addr during a write strobe SHALL be the address held when the commit byte arrived; an address phase in the strobe cycle takes effect only after it.
REQ-022 Data phase w=0,l=1 SHALL advance read pointer, wrapping NIBBLES-1 -> 0; w=0,l=0 SHALL be a no-op.
REQ-023 bus_in SHALL combinationally equal nibble[read pointer] (0 = most significant) of io_rdata when io_active else mem_rdata.
REQ-024 mem_wdata SHALL hold its value between commits.

Reset
REQ-025 rst SHALL clear mem_addr, mem_wdata, assembly, read pointer, io_sel, io_active, mem_we, io_we, io_re to 0, overriding any simultaneous bus_out decode, including mid-assembly.

Configuration
REQ-026 With NMB_AUTOINC_EN defined: mem_addr SHALL increment by 1 (wrap 2^ADDR_WIDTH-1 -> 0) in the mem_we cycle and on read-pointer wrap while io_active=0; a same-cycle address phase wins.
REQ-027 Without NMB_AUTOINC_EN, mem_addr SHALL change only on address phases and reset.

Verification (WORD_WIDTH=12, ADDR_WIDTH=12)
REQ-028 bus_out 0xE9 then 0x9C -> mem_addr = 0xA5C.
REQ-029 bus_out 0x23, 0x2F, 0x37 -> next cycle mem_we=1 for one cycle, mem_wdata=0x3F7, io_we=0.
REQ-030 mem_rdata=0x8B1, address phase, then 0x10 x3 -> bus_in 0x8, 0xB, 0x1, 0x8.
REQ-031 bus_out 0x75 -> io_active=1, io_sel=0x15, io_re one cycle; then 0x23,0x2F,0x37 -> io_we=1, mem_we=0; then 0xC0 -> io_active=0.
REQ-032 bus_out 0x23, rst one cycle, 0x35 -> mem_wdata=0x005.
REQ-033 mem_addr=0xFFF, write 0x23,0x2F,0x37 -> with NMB_AUTOINC_EN mem_addr=0x000 after strobe; without, 0xFFF.
